// File: rtl/uart_tx_core.sv
// UART transmitter: start bit, 7/8 LSB-first data bits, optional parity, 1/2 stop bits.
// Baud divisor comes from a fixed table derived from CLK_FREQ; all settings are latched at send.
`timescale 1ns/1ps
module uart_tx_core #(
  parameter int CLK_FREQ = 100000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [2:0] baud_sel,
  input  logic       data_size,
  input  logic       parity_en,
  input  logic [1:0] parity_mode,
  input  logic       stop_bit_size,
  input  logic [7:0] data,
  output logic       ready,
  input  logic       send,
  output logic       tx,
  output logic       uartClock
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  function automatic logic [31:0] baud_div(input logic [2:0] sel);
    logic [31:0] div_v;
    case (sel)
      3'd0:    div_v = 32'(CLK_FREQ) / 32'd9600;
      3'd1:    div_v = 32'(CLK_FREQ) / 32'd19200;
      3'd2:    div_v = 32'(CLK_FREQ) / 32'd38400;
      3'd3:    div_v = 32'(CLK_FREQ) / 32'd57600;
      3'd4:    div_v = 32'(CLK_FREQ) / 32'd115200;
      3'd5:    div_v = 32'(CLK_FREQ) / 32'd230400;
      3'd6:    div_v = 32'(CLK_FREQ) / 32'd460800;
      default: div_v = 32'(CLK_FREQ) / 32'd921600;
    endcase
    return div_v;
  endfunction

  // Even parity covers only the bits actually sent (bit 7 excluded for 7-bit characters)
  function automatic logic parity_bit(input logic [7:0] d, input logic size8, input logic [1:0] mode);
    logic even_v;
    logic par_v;
    even_v = ^(size8 ? d : {1'b0, d[6:0]});
    case (mode)
      2'b11:   par_v = ~even_v;
      2'b10:   par_v = even_v;
      2'b01:   par_v = 1'b1;
      default: par_v = 1'b0;
    endcase
    return par_v;
  endfunction

  state_t      state_r, state_s;
  logic [31:0] cnt_r, cnt_s;
  logic [31:0] div_r, div_s;
  logic [2:0]  bit_r, bit_s;
  logic [7:0]  shift_r, shift_s;
  logic        size_r, par_en_r, par_r, stop2_r;
  logic        tx_r, tx_s, ready_r, ready_s, uclk_r, uclk_s;
  logic        load_s, bit_end_s;

  assign tx        = tx_r;
  assign ready     = ready_r;
  assign uartClock = uclk_r;

  // Next-state and next-output logic for the frame sequencer
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    bit_s     = bit_r;
    shift_s   = shift_r;
    tx_s      = tx_r;
    ready_s   = ready_r;
    load_s    = 1'b0;
    bit_end_s = (cnt_r == div_r - 32'd1);
    if (!en) begin
      state_s = IDLE;
      cnt_s   = 32'd0;
      bit_s   = 3'd0;
      tx_s    = 1'b1;
      ready_s = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          cnt_s = 32'd0;
          bit_s = 3'd0;
          if (send) begin
            load_s  = 1'b1;
            shift_s = data;
            state_s = START;
            tx_s    = 1'b0;
            ready_s = 1'b0;
          end else begin
            tx_s    = 1'b1;
            ready_s = 1'b1;
          end
        end
        START: begin
          if (bit_end_s) begin
            state_s = DATA;
            cnt_s   = 32'd0;
            bit_s   = 3'd0;
            tx_s    = shift_r[0];
          end else begin
            cnt_s = cnt_r + 32'd1;
          end
        end
        DATA: begin
          if (bit_end_s) begin
            cnt_s = 32'd0;
            if (bit_r == (size_r ? 3'd7 : 3'd6)) begin
              bit_s = 3'd0;
              if (par_en_r) begin
                state_s = PARITY;
                tx_s    = par_r;
              end else begin
                state_s = STOP;
                tx_s    = 1'b1;
              end
            end else begin
              bit_s   = bit_r + 3'd1;
              shift_s = {1'b0, shift_r[7:1]};
              tx_s    = shift_r[1];
            end
          end else begin
            cnt_s = cnt_r + 32'd1;
          end
        end
        PARITY: begin
          if (bit_end_s) begin
            state_s = STOP;
            cnt_s   = 32'd0;
            bit_s   = 3'd0;
            tx_s    = 1'b1;
          end else begin
            cnt_s = cnt_r + 32'd1;
          end
        end
        STOP: begin
          if (bit_end_s) begin
            cnt_s = 32'd0;
            if (stop2_r && (bit_r == 3'd0)) begin
              bit_s = 3'd1;
            end else begin
              state_s = IDLE;
              bit_s   = 3'd0;
              tx_s    = 1'b1;
              ready_s = 1'b1;
            end
          end else begin
            cnt_s = cnt_r + 32'd1;
          end
        end
        default: begin
          state_s = IDLE;
          cnt_s   = 32'd0;
          bit_s   = 3'd0;
          tx_s    = 1'b1;
          ready_s = 1'b0;
        end
      endcase
    end
    div_s  = load_s ? baud_div(baud_sel) : div_r;
    uclk_s = (state_s != IDLE) && (cnt_s < (div_s >> 1));
  end

  // Sequencer state, counters and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= IDLE;
      cnt_r   <= 32'd0;
      bit_r   <= 3'd0;
      shift_r <= 8'd0;
      tx_r    <= 1'b1;
      ready_r <= 1'b1;
      uclk_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      bit_r   <= bit_s;
      shift_r <= shift_s;
      tx_r    <= tx_s;
      ready_r <= ready_s;
      uclk_r  <= uclk_s;
    end
  end

  // Frame settings captured when a character is accepted
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_r    <= baud_div(3'd0);
      size_r   <= 1'b0;
      par_en_r <= 1'b0;
      par_r    <= 1'b0;
      stop2_r  <= 1'b0;
    end else if (load_s) begin
      div_r    <= div_s;
      size_r   <= data_size;
      par_en_r <= parity_en;
      par_r    <= parity_bit(data, data_size, parity_mode);
      stop2_r  <= stop_bit_size;
    end else begin
      div_r    <= div_r;
      size_r   <= size_r;
      par_en_r <= par_en_r;
      par_r    <= par_r;
      stop2_r  <= stop2_r;
    end
  end

endmodule

// File: tb/tb_uart_tx_core.sv
// Scoreboard bench for uart_tx_core: expected line bits are queued when a character
// is sent and compared at mid-bit as the frame appears on tx.
`timescale 1ns/1ps
module tb_uart_tx_core;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [2:0] baud_sel;
  logic       data_size;
  logic       parity_en;
  logic [1:0] parity_mode;
  logic       stop_bit_size;
  logic [7:0] data;
  logic       ready;
  logic       send;
  logic       tx;
  logic       uartClock;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  bit exp_q[$];

  uart_tx_core #(.CLK_FREQ(100000000)) dut (
    .clk(clk), .rst(rst), .en(en), .baud_sel(baud_sel), .data_size(data_size),
    .parity_en(parity_en), .parity_mode(parity_mode), .stop_bit_size(stop_bit_size),
    .data(data), .ready(ready), .send(send), .tx(tx), .uartClock(uartClock)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference frame: start, data LSB first, parity, stop bits
  task automatic push_frame(input logic [7:0] d, input bit sz8, input bit pen,
                            input logic [1:0] pm, input bit st2, output int nbits);
    int nd;
    bit p;
    nd = sz8 ? 8 : 7;
    p = 1'b0;
    exp_q.push_back(1'b0);
    for (int i = 0; i < nd; i++) begin
      exp_q.push_back(d[i]);
      p = p ^ d[i];
    end
    nbits = 1 + nd + 1;
    if (pen) begin
      case (pm)
        2'b11: exp_q.push_back(~p);
        2'b10: exp_q.push_back(p);
        2'b01: exp_q.push_back(1'b1);
        default: exp_q.push_back(1'b0);
      endcase
      nbits++;
    end
    exp_q.push_back(1'b1);
    if (st2) begin
      exp_q.push_back(1'b1);
      nbits++;
    end
  endtask

  task automatic config_frame(input logic [2:0] bs, input logic [7:0] d, input bit sz8,
                              input bit pen, input logic [1:0] pm, input bit st2);
    baud_sel = bs; data = d; data_size = sz8; parity_en = pen;
    parity_mode = pm; stop_bit_size = st2;
  endtask

  // Follows one frame from its start bit to ready, popping expected bits at mid-bit
  task automatic capture_frame(input int div, input int nbits, input bit hold,
                               output int start_cyc, output int hi, output int lo);
    int w;
    int rdy_err;
    bit exp_b;
    logic [7:0] sd; logic [2:0] sb; logic [1:0] spm; logic sds, spe, sst;
    w = 0; rdy_err = 0; hi = 0; lo = 0; start_cyc = -1;
    sd = data; sb = baud_sel; spm = parity_mode; sds = data_size; spe = parity_en; sst = stop_bit_size;
    while (w < 50) begin
      @(negedge clk);
      w++;
      if (tx === 1'b0) break;
    end
    checks++;
    if (tx !== 1'b0) begin
      fails++;
      $display("FAIL start_timeout: tx=%b after %0d cycles, required start bit 0", tx, w);
      for (int i = 0; i < nbits; i++) if (exp_q.size() > 0) void'(exp_q.pop_front());
      send = 1'b0;
      return;
    end
    start_cyc = cyc;
    for (int c = 0; c <= nbits * div; c++) begin
      if (c > 0) @(negedge clk);
      if (c == 1 && !hold) send = 1'b0;
      if (c == 2) begin
        data = ~sd; baud_sel = sb ^ 3'd1; parity_mode = ~spm;
        data_size = ~sds; parity_en = ~spe; stop_bit_size = ~sst;
      end
      if (c == nbits * div - 2) begin
        data = sd; baud_sel = sb; parity_mode = spm;
        data_size = sds; parity_en = spe; stop_bit_size = sst;
      end
      if (c < nbits * div && ready !== 1'b0) rdy_err++;
      if (c < div) begin
        if (uartClock === 1'b1) hi++;
        if (uartClock === 1'b0) lo++;
      end
      if (c % div == div / 2 && c < nbits * div) begin
        checks++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL scoreboard_empty: bit %0d tx=%b, no expected value queued", c / div, tx);
        end else begin
          exp_b = exp_q.pop_front();
          if (tx !== exp_b) begin
            fails++;
            $display("FAIL frame_bit%0d: tx=%b required %b", c / div, tx, exp_b);
          end
        end
      end
    end
    checks++;
    if (rdy_err != 0) begin
      fails++;
      $display("FAIL ready_busy: ready high in %0d frame cycles, required 0", rdy_err);
    end
    checks++;
    if (ready !== 1'b1 || tx !== 1'b1 || uartClock !== 1'b0) begin
      fails++;
      $display("FAIL frame_end: ready=%b tx=%b uartClock=%b after %0d cycles, required 1 1 0",
               ready, tx, uartClock, nbits * div);
    end
  endtask

  task automatic run_frame(input int div, input bit hold, output int hi, output int lo);
    int nbits, sc;
    push_frame(data, data_size, parity_en, parity_mode, stop_bit_size, nbits);
    @(negedge clk);
    send = 1'b1;
    capture_frame(div, nbits, hold, sc, hi, lo);
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b1; send = 1'b0;
    config_frame(3'd6, 8'h00, 1'b1, 1'b0, 2'b00, 1'b0);
    #10;
    checks++;
    if (tx !== 1'b1 || ready !== 1'b1 || uartClock !== 1'b0) begin
      fails++;
      $display("FAIL reset_values: tx=%b ready=%b uartClock=%b, required 1 1 0", tx, ready, uartClock);
    end
    rst = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if (tx !== 1'b1 || ready !== 1'b1 || uartClock !== 1'b0) begin
      fails++;
      $display("FAIL idle_values: tx=%b ready=%b uartClock=%b, required 1 1 0", tx, ready, uartClock);
    end
  endtask

  task automatic test_8o1();
    int hi, lo;
    config_frame(3'd6, 8'hAA, 1'b1, 1'b1, 2'b11, 1'b0);
    run_frame(217, 1'b0, hi, lo);
  endtask

  task automatic test_7e2();
    int hi, lo;
    config_frame(3'd6, 8'h81, 1'b0, 1'b1, 2'b10, 1'b1);
    run_frame(217, 1'b0, hi, lo);
  endtask

  task automatic test_parity_modes();
    int hi, lo;
    config_frame(3'd6, 8'h3C, 1'b1, 1'b1, 2'b01, 1'b0);
    run_frame(217, 1'b0, hi, lo);
    config_frame(3'd6, 8'hC7, 1'b1, 1'b1, 2'b00, 1'b0);
    run_frame(217, 1'b0, hi, lo);
    config_frame(3'd6, 8'h96, 1'b1, 1'b0, 2'b11, 1'b0);
    run_frame(217, 1'b0, hi, lo);
  endtask

  task automatic test_baud_sel();
    int hi, lo;
    config_frame(3'd4, 8'h5A, 1'b1, 1'b0, 2'b00, 1'b0);
    run_frame(868, 1'b0, hi, lo);
    checks++;
    if (hi != 434 || lo != 434) begin
      fails++;
      $display("FAIL uartclock_duty: high=%0d low=%0d cycles, required 434 434", hi, lo);
    end
  endtask

  task automatic start_zero_frame();
    int w;
    config_frame(3'd6, 8'h00, 1'b1, 1'b0, 2'b00, 1'b0);
    @(negedge clk);
    send = 1'b1;
    w = 0;
    while (w < 50 && tx !== 1'b0) begin
      @(negedge clk);
      w++;
    end
    send = 1'b0;
    repeat (217 + 50) @(negedge clk);
    checks++;
    if (tx !== 1'b0 || uartClock !== 1'b1) begin
      fails++;
      $display("FAIL mid_frame: tx=%b uartClock=%b, required 0 1", tx, uartClock);
    end
  endtask

  task automatic test_abort_en();
    int err;
    start_zero_frame();
    en = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (tx !== 1'b1 || ready !== 1'b0 || uartClock !== 1'b0) begin
      fails++;
      $display("FAIL en_abort: tx=%b ready=%b uartClock=%b, required 1 0 0", tx, ready, uartClock);
    end
    send = 1'b1;
    err = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx !== 1'b1 || ready !== 1'b0) err++;
    end
    checks++;
    if (err != 0) begin
      fails++;
      $display("FAIL en_low_send: %0d cycles with tx/ready wrong, required 0", err);
    end
    send = 1'b0;
    en = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (tx !== 1'b1 || ready !== 1'b1) begin
      fails++;
      $display("FAIL en_restore: tx=%b ready=%b, required 1 1", tx, ready);
    end
  endtask

  task automatic test_abort_rst();
    start_zero_frame();
    rst = 1'b0;
    #2;
    checks++;
    if (tx !== 1'b1 || ready !== 1'b1 || uartClock !== 1'b0) begin
      fails++;
      $display("FAIL rst_abort: tx=%b ready=%b uartClock=%b, required 1 1 0", tx, ready, uartClock);
    end
    @(negedge clk);
    rst = 1'b1;
    repeat (300) @(negedge clk);
    checks++;
    if (tx !== 1'b1 || ready !== 1'b1) begin
      fails++;
      $display("FAIL rst_idle: tx=%b ready=%b, required 1 1", tx, ready);
    end
  endtask

  task automatic test_back_to_back();
    int nbits, s1, s2, hi, lo;
    config_frame(3'd7, 8'h33, 1'b1, 1'b1, 2'b10, 1'b0);
    push_frame(data, data_size, parity_en, parity_mode, stop_bit_size, nbits);
    push_frame(data, data_size, parity_en, parity_mode, stop_bit_size, nbits);
    @(negedge clk);
    send = 1'b1;
    capture_frame(108, nbits, 1'b1, s1, hi, lo);
    capture_frame(108, nbits, 1'b0, s2, hi, lo);
    checks++;
    if (s2 - s1 != nbits * 108 + 1) begin
      fails++;
      $display("FAIL b2b_gap: second start %0d cycles after first, required %0d", s2 - s1, nbits * 108 + 1);
    end
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_left: %0d expected bits unconsumed, required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_8o1();
    test_7e2();
    test_parity_modes();
    test_baud_sel();
    test_abort_en();
    test_abort_rst();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_core.md
Name: uart_tx_core

Overview:
Configurable UART transmitter. Serialises one 7- or 8-bit character per request into a standard asynchronous frame: start bit, LSB-first data, optional parity, and 1 or 2 stop bits. The baud rate is selected at runtime from a fixed table derived from the system clock. It sits between a parallel host interface (valid/ready-style send/ready) and the TX pin, and exports its bit-rate clock for observation.

Parameters:
CLK_FREQ, 100000000, system clock frequency in Hz; all baud divisors are derived from it.

Ports:
clk  input  1  system clock, rising-edge active
rst  input  1  asynchronous reset, active-low
en  input  1  module enable
baud_sel  input  3  baud-rate select
data_size  input  1  0 = 7 data bits, 1 = 8 data bits
parity_en  input  1  1 = append parity bit
parity_mode  input  2  11 = odd, 10 = even, 01 = mark (1), 00 = space (0)
stop_bit_size  input  1  0 = one stop bit, 1 = two stop bits
data  input  8  character to send; bit 7 ignored when data_size = 0
ready  output  1  high when idle and able to accept send
send  input  1  transmit request, level-sensitive
tx  output  1  serial line, idle high
uartClock  output  1  bit-rate clock, active only during a frame

Behaviour:
- Reset (rst low, asynchronous):
  - tx = 1, ready = 1 (if en = 1), uartClock = 0.
  - FSM goes to IDLE; counters are cleared.
- Baud table (baud_sel 0..7):
  - Rates: 9600, 19200, 38400, 57600, 115200, 230400, 460800, 921600.
  - Divisor DIV = CLK_FREQ / baud, truncated.
  - At 100 MHz: 10416, 5208, 2604, 1736, 868, 434, 217, 108 clocks per bit.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE:
  - tx = 1, ready = en.
  - If en & send are high on a clock edge:
    - data, data_size, parity_en, parity_mode, stop_bit_size and baud_sel are latched.
    - ready falls, and tx goes 0 on that same edge (START).
- Bit timing: every bit lasts exactly DIV clocks of the latched divisor.
- Frame sequence:
  - START: tx = 0.
  - DATA: data[0] first; 7 or 8 bits.
  - PARITY: only if parity_en.
  - STOP: tx = 1 for 1 or 2 bit times.
- Parity bit value:
  - even = XOR of the transmitted data bits (7 or 8 bits only).
  - odd = inverse of the even value.
  - mark = 1; space = 0.
- Frame length in bits: 1 + (7 or 8) + parity_en + (1 or 2). Range is 9 to 12 bit times.
- ready rises on the edge that ends the last stop bit, with tx = 1.
  - If send is still high on that edge, it is accepted on the next edge. Back-to-back frames are separated by 1 clock of idle high.
- Input changes during a frame have no effect on it, because everything is latched.
- uartClock:
  - During a frame, it is high for the first DIV/2 clocks of each bit period and low for the rest.
  - In IDLE it is held 0.
- en low:
  - Any frame in progress is aborted; FSM returns to IDLE.
  - tx = 1, ready = 0, uartClock = 0, send is ignored.
- send while busy: ignored, not queued.
- Reset mid-frame: immediate return to the reset values, with no partial stop bit.

Test Plan:
- Reset-to-idle:
  - Stimulus: rst low 10 ns, then high.
  - Required: tx = 1, ready = 1, uartClock = 0 until the first send.
- Baseline 8O1 frame:
  - Stimulus: en = 1, baud_sel = 6 (217 clk/bit), data_size = 1, parity_en = 1, parity_mode = 11, stop_bit_size = 0, data = 0xAA; send high for 2 cycles.
  - Required tx sequence: 0, 0,1,0,1,0,1,0,1, 1 (parity), 1 (stop).
  - Each bit is 217 cycles and the frame is 11 × 217 cycles; ready is low throughout and reasserts afterwards.
- 7E2 frame:
  - Stimulus: data = 0x81, data_size = 0, parity_mode = 10, stop_bit_size = 1.
  - Required: 7 data bits 1,0,0,0,0,0,0, parity 1, two stop bits; 11 bit times in total.
- Parity mark/space and parity disabled:
  - Stimulus: parity_mode 01, then 00; then parity_en = 0.
  - Required: parity bit fixed at 1, then fixed at 0; with parity_en = 0 the frame has no parity bit and is 10 bits for 8N1.
- Baud select:
  - Stimulus: baud_sel = 4.
  - Required: each bit period is 868 cycles; uartClock high for 434 cycles, low for 434 cycles per bit.
- Abort and hold:
  - Stimulus: drop en mid-data, or pulse rst low mid-frame.
  - Required: tx returns to 1 immediately.
  - Stimulus: hold send high across a frame.
  - Required: second frame starts 1 cycle after ready rises.
